// File: rtl/proc_pkg.sv
// Shared processor definitions for the fetch unit: state encoding, opcode
// field layout, halt opcode and default PC configuration.
package proc_pkg;

    // Fetch sequencer states. S_HALT is only reachable with FETCH_HALT_EN.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    // Instruction field bounds: [31:27] opcode, [26:23] func.
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int FUNC_HI = 26;
    localparam int FUNC_LO = 23;

    // Opcode that parks the fetch unit when halting is enabled.
    localparam logic [4:0] OPC_HALT = 5'b11111;

    // Default PC configuration.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

    // Extract the opcode field from an instruction word.
    function automatic logic [4:0] get_opcode(input logic [31:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's bus-side signals: instruction memory req/ack,
// decode valid/ready, and the branch-resolution redirect.
// The halted output exists only when FETCH_HALT_EN is defined.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    // Instruction memory read channel
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // Decode stage channel
    logic              instr_valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    // Redirect from branch/jump resolution
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

`ifdef FETCH_HALT_EN
    logic              halted;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, halted,
        input  mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, halted,
        output mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );
`else
    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );
`endif

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register. A redirect load takes priority over the
// sequential increment; arithmetic wraps modulo 2^ADDR_W.
module pc_reg
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: redirect target first, otherwise step past the fetched word.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    // PC storage, cleared to the reset vector asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word read at a time to
// instruction memory and hands the fetched word to decode. Redirects load a
// new PC and cause any in-flight fetch to be discarded. No prefetch.
// Optional feature macro: FETCH_HALT_EN (halt opcode parks the unit).
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               CLK,
    input  logic               RESET,
    instr_fetch_unit_if.master bus
);

    fetch_state_e      state_q,       state_d;
    logic              mem_req_q,     mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_q,       instr_d;
    logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;
`ifdef FETCH_HALT_EN
    logic              halted_q,      halted_d;
`endif

    logic              pc_inc;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] fetch_target;
    logic              is_halt_word;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .CLK       (CLK),
        .RESET     (RESET),
        .inc_i     (pc_inc),
        .load_i    (bus.redirect_valid),
        .load_pc_i (bus.redirect_pc),
        .pc_o      (pc)
    );

    // Whenever a new request is launched the address is the PC value that
    // will be live next cycle; no increment ever coincides with a launch.
    assign fetch_target = bus.redirect_valid ? bus.redirect_pc : pc;

`ifdef FETCH_HALT_EN
    assign is_halt_word = (get_opcode(instr_q) == OPC_HALT);
`else
    assign is_halt_word = 1'b0;
`endif

    // Sequencer next state and registered-output next values.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
`ifdef FETCH_HALT_EN
        halted_d      = halted_q;
`endif
        pc_inc        = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (!mem_req_q) begin
                    // Only seen right after reset: launch the first read.
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_target;
                end else if (bus.mem_ack) begin
                    if (bus.redirect_valid) begin
                        // Word is stale; request again at the redirect target.
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_target;
                    end else begin
                        mem_req_d     = 1'b0;
                        instr_d       = bus.mem_rdata;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                        pc_inc        = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    // Request cannot be withdrawn; let it finish and drop it.
                    state_d = S_DROP;
                end
            end

            S_HOLD: begin
                if (bus.redirect_valid) begin
                    instr_valid_d = 1'b0;
                    mem_req_d     = 1'b1;
                    mem_addr_d    = fetch_target;
                    state_d       = S_REQ;
                end else if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (is_halt_word) begin
`ifdef FETCH_HALT_EN
                        halted_d = 1'b1;
`endif
                        state_d  = S_HALT;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc;
                        state_d    = S_REQ;
                    end
                end
            end

            S_DROP: begin
                if (bus.mem_ack) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_target;
                    state_d    = S_REQ;
                end
            end

            S_HALT: begin
                if (bus.redirect_valid) begin
`ifdef FETCH_HALT_EN
                    halted_d   = 1'b0;
`endif
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_target;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d   = S_REQ;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_REQ;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
`ifdef FETCH_HALT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
`ifdef FETCH_HALT_EN
            halted_q      <= halted_d;
`endif
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
`ifdef FETCH_HALT_EN
    assign bus.halted      = halted_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. A main instance (RESET_PC=0) runs
// against a memory model with programmable ack latency; a second instance
// (RESET_PC=FFFF_FFFC) exercises PC wrap. Halt checks need FETCH_HALT_EN.
module tb_instr_fetch_unit;

    logic CLK;
    logic RESET;

    instr_fetch_unit_if #(.ADDR_W(32)) busIf ();
    instr_fetch_unit_if #(.ADDR_W(32)) wrapIf ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (busIf)
    );

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'hFFFF_FFFC),
        .PC_STEP  (4)
    ) dutWrap (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (wrapIf)
    );

    int   total;
    int   bad;
    int   memLat;
    int   memCnt;
    int   wrapCnt;
    logic haltWordEn;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Main memory: ack arrives memLat cycles after the first request cycle.
    assign busIf.mem_ack   = busIf.mem_req && (memCnt == memLat);
    assign busIf.mem_rdata = (haltWordEn && busIf.mem_addr == 32'h8) ? 32'hF800_0000
                                                                      : 32'h1000_0000 + busIf.mem_addr;

    // Wrap-instance memory: fixed one-cycle latency.
    assign wrapIf.mem_ack        = wrapIf.mem_req && (wrapCnt == 1);
    assign wrapIf.mem_rdata      = 32'h1000_0000 + wrapIf.mem_addr;
    assign wrapIf.redirect_valid = 1'b0;
    assign wrapIf.redirect_pc    = 32'h0;

    // Count cycles of each outstanding request for both memory models.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            memCnt  <= 0;
            wrapCnt <= 0;
        end else begin
            memCnt  <= (!busIf.mem_req || busIf.mem_ack) ? 0 : memCnt + 1;
            wrapCnt <= (!wrapIf.mem_req || wrapIf.mem_ack) ? 0 : wrapCnt + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle of decode/redirect inputs, then return them to idle.
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
        busIf.instr_ready    = rdy;
        busIf.redirect_valid = redir;
        busIf.redirect_pc    = rpc;
        tick();
        busIf.instr_ready    = 1'b0;
        busIf.redirect_valid = 1'b0;
        busIf.redirect_pc    = 32'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    task automatic waitValid(input string tag, input int budget);
        for (int i = 0; i < budget && !busIf.instr_valid; i++) tick();
        checkOutput(tag, {31'b0, busIf.instr_valid}, 32'h1);
    endtask

    task automatic waitAck(input string tag, input int budget);
        for (int i = 0; i < budget && !busIf.mem_ack; i++) tick();
        checkOutput(tag, {31'b0, busIf.mem_ack}, 32'h1);
    endtask

    initial begin
        total                = 0;
        bad                  = 0;
        memLat               = 1;
        haltWordEn           = 1'b0;
        wrapIf.instr_ready   = 1'b0;
        busIf.instr_ready    = 1'b0;
        busIf.redirect_valid = 1'b0;
        busIf.redirect_pc    = 32'h0;
        RESET                = 1'b1;

        // Reset state
        repeat (3) tick();
        checkOutput("rst mem_req",     {31'b0, busIf.mem_req}, 32'h0);
        checkOutput("rst mem_addr",    busIf.mem_addr, 32'h0);
        checkOutput("rst instr_valid", {31'b0, busIf.instr_valid}, 32'h0);
        checkOutput("rst instr",       busIf.instr, 32'h0);
        checkOutput("rst instr_pc",    busIf.instr_pc, 32'h0);
        checkOutput("rst wrap addr",   wrapIf.mem_addr, 32'hFFFF_FFFC);
        RESET = 1'b0;

        // Sequential fetch, one-cycle memory latency
        tick();
        checkOutput("seq0 req",  {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("seq0 addr", busIf.mem_addr, 32'h0);
        tick();
        checkOutput("seq0 addr stable", busIf.mem_addr, 32'h0);
        tick();
        checkOutput("seq0 valid", {31'b0, busIf.instr_valid}, 32'h1);
        checkOutput("seq0 instr", busIf.instr, 32'h1000_0000);
        checkOutput("seq0 pc",    busIf.instr_pc, 32'h0);
        checkOutput("seq0 req low", {31'b0, busIf.mem_req}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("seq1 valid low", {31'b0, busIf.instr_valid}, 32'h0);
        checkOutput("seq1 req",  {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("seq1 addr", busIf.mem_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("seq1 instr", busIf.instr, 32'h1000_0004);
        checkOutput("seq1 pc",    busIf.instr_pc, 32'h4);

        // Backpressure: word held, no new request
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("bp valid", {31'b0, busIf.instr_valid}, 32'h1);
            checkOutput("bp instr", busIf.instr, 32'h1000_0004);
            checkOutput("bp pc",    busIf.instr_pc, 32'h4);
            checkOutput("bp req",   {31'b0, busIf.mem_req}, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("seq2 req",  {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("seq2 addr", busIf.mem_addr, 32'h8);
        waitValid("seq2 wait", 10);
        checkOutput("seq2 instr", busIf.instr, 32'h1000_0008);

        // Redirect on cycle 2 of a 4-cycle-latency request
        memLat = 4;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("drop req addr", busIf.mem_addr, 32'hC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h100);
        checkOutput("drop req held", {31'b0, busIf.mem_req}, 32'h1);
        for (int i = 0; i < 10 && !busIf.mem_ack; i++) begin
            checkOutput("drop addr held", busIf.mem_addr, 32'hC);
            checkOutput("drop no valid",  {31'b0, busIf.instr_valid}, 32'h0);
            tick();
        end
        checkOutput("drop ack", {31'b0, busIf.mem_ack}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("drop new req",  {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("drop new addr", busIf.mem_addr, 32'h100);
        checkOutput("drop stale",    {31'b0, busIf.instr_valid}, 32'h0);
        waitValid("redir1 wait", 20);
        checkOutput("redir1 instr", busIf.instr, 32'h1000_0100);
        checkOutput("redir1 pc",    busIf.instr_pc, 32'h100);

        // Redirect in the same cycle as mem_ack
        memLat = 2;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("ackredir addr", busIf.mem_addr, 32'h104);
        waitAck("ackredir wait ack", 10);
        applyStimulus(1'b0, 1'b1, 32'h200);
        checkOutput("ackredir no valid", {31'b0, busIf.instr_valid}, 32'h0);
        checkOutput("ackredir req",      {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("ackredir addr new", busIf.mem_addr, 32'h200);
        waitValid("ackredir wait", 20);
        checkOutput("ackredir instr", busIf.instr, 32'h1000_0200);
        checkOutput("ackredir pc",    busIf.instr_pc, 32'h200);

        // Redirect in the same cycle as instr_ready
        applyStimulus(1'b1, 1'b1, 32'h300);
        checkOutput("rdyredir valid", {31'b0, busIf.instr_valid}, 32'h0);
        checkOutput("rdyredir req",   {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("rdyredir addr",  busIf.mem_addr, 32'h300);
        waitValid("rdyredir wait", 20);
        checkOutput("rdyredir pc", busIf.instr_pc, 32'h300);

        // PC wrap on the second instance (idle in hold since reset)
        checkOutput("wrap valid", {31'b0, wrapIf.instr_valid}, 32'h1);
        checkOutput("wrap pc",    wrapIf.instr_pc, 32'hFFFF_FFFC);
        checkOutput("wrap instr", wrapIf.instr, 32'h0FFF_FFFC);
        wrapIf.instr_ready = 1'b1;
        tick();
        wrapIf.instr_ready = 1'b0;
        checkOutput("wrap req",  {31'b0, wrapIf.mem_req}, 32'h1);
        checkOutput("wrap addr", wrapIf.mem_addr, 32'h0);

        // Opcode 11111 word at 0x8
        haltWordEn = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h8);
        checkOutput("hw req addr", busIf.mem_addr, 32'h8);
        waitValid("hw wait", 20);
        checkOutput("hw instr", busIf.instr, 32'hF800_0000);
        checkOutput("hw pc",    busIf.instr_pc, 32'h8);
`ifdef FETCH_HALT_EN
        checkOutput("hw halted pre", {31'b0, busIf.halted}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("halt halted", {31'b0, busIf.halted}, 32'h1);
        checkOutput("halt valid",  {31'b0, busIf.instr_valid}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("halt hold halted", {31'b0, busIf.halted}, 32'h1);
            checkOutput("halt hold req",    {31'b0, busIf.mem_req}, 32'h0);
        end
        applyStimulus(1'b0, 1'b1, 32'h40);
        checkOutput("unhalt halted", {31'b0, busIf.halted}, 32'h0);
        checkOutput("unhalt req",    {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("unhalt addr",   busIf.mem_addr, 32'h40);
        waitValid("unhalt wait", 20);
        checkOutput("unhalt instr", busIf.instr, 32'h1000_0040);
`else
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("hw no halt req",  {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("hw no halt addr", busIf.mem_addr, 32'hC);
        waitValid("hw next wait", 20);
        checkOutput("hw next instr", busIf.instr, 32'h1000_000C);
`endif
        haltWordEn = 1'b0;

        // Reset in the middle of a request
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("mid req before", {31'b0, busIf.mem_req}, 32'h1);
        RESET = 1'b1;
        #1;
        checkOutput("mid rst req",   {31'b0, busIf.mem_req}, 32'h0);
        checkOutput("mid rst valid", {31'b0, busIf.instr_valid}, 32'h0);
        checkOutput("mid rst addr",  busIf.mem_addr, 32'h0);
        tick();
        tick();
        RESET = 1'b0;
        tick();
        checkOutput("mid restart req",  {31'b0, busIf.mem_req}, 32'h1);
        checkOutput("mid restart addr", busIf.mem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, want finished");
        $fatal(1, "[TB] time limit exceeded");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies the 32-bit instruction word that the processor datapath decodes. It owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents the fetched word, with its PC, to the decode stage over a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and discards stale fetches.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC loaded on RESET.
- PC_STEP, 4, byte increment between sequential instructions.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; valid while mem_req=1.
- mem_ack  in  1  memory returns mem_rdata this cycle; ends the request.
- mem_rdata  in  32  instruction word; sampled only when mem_ack=1.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr  out  32  instruction word. Fields follow the processor format: [31:27] opcode, [26:23] func.
- instr_pc  out  ADDR_W  address the word was fetched from.
- instr_ready  in  1  decode accepts instr this cycle.
- redirect_valid  in  1  load a new PC; flush everything in flight.
- redirect_pc  in  ADDR_W  target PC for a redirect.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; state=S_REQ.
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Outputs are registered. mem_req first rises in the first cycle after RESET deasserts.
- States:
  - S_REQ: mem_req=1, mem_addr=pc.
    - mem_ack: instr<=mem_rdata, instr_pc<=pc, pc<=pc+PC_STEP, instr_valid<=1, go S_HOLD.
  - S_HOLD: mem_req=0, instr_valid=1.
    - instr_ready: instr_valid<=0, go S_REQ. The next request is asserted the following cycle.
  - S_DROP: mem_req=1, mem_addr held at the stale address.
    - mem_ack: discard data, go S_REQ. S_REQ issues at the new pc.
- Memory protocol:
  - mem_req and mem_addr stay stable from assertion until the mem_ack cycle inclusive.
  - Request is never withdrawn.
  - Latency is unbounded; mem_ack with mem_req=0 is ignored.
- Redirect rules (pc<=redirect_pc in every case):
  - S_REQ, no ack: go S_DROP.
  - S_REQ, same cycle as ack: discard data; instr_valid stays 0; stay S_REQ.
  - S_HOLD: instr_valid<=0; go S_REQ. Redirect beats a simultaneous instr_ready; that handshake does not count.
  - S_DROP: only pc is updated; the latest redirect wins.
- Decode handshake:
  - instr, instr_pc stay stable while instr_valid=1 and instr_ready=0.
  - Steady-state throughput: 1 instruction per (mem latency + 2) cycles; no prefetch.
- pc arithmetic is modulo 2^ADDR_W; wraps silently at the top.
- pc is never misaligned by the unit; redirect_pc is used as given.
- RESET mid-request: state clears immediately; any later mem_ack is ignored, since mem_req=0.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - Adds output halted (1 bit, reset 0).
  - When a word with opcode [31:27]=5'b11111 is accepted by decode, go to S_HALT: mem_req=0, instr_valid=0, halted=1.
  - Only redirect_valid leaves S_HALT: pc<=redirect_pc, halted<=0, go S_REQ.
- Undefined: no halted port; opcode 5'b11111 is fetched like any other word.

Decomposition:
- Shared package proc_pkg holds:
  - Fetch state enum (S_REQ, S_HOLD, S_DROP, S_HALT).
  - OPC_HALT=5'b11111.
  - Opcode field bounds 31:27.
  - Default RESET_PC and PC_STEP.
- One sub-module, pc_reg: PC register with reset value, increment and redirect load, priority redirect > increment.
- FSM and output registers stay in the top.

Test Plan:
- Reset/sequential: RESET 3 cycles, memory 1-cycle ack returning 32'h1000_0000+addr.
  - Expect mem_addr 0x0, 0x4, 0x8.
  - Expect instr 0x1000_0000, 0x1000_0004, with instr_pc matching.
  - Expect a new mem_req the cycle after each instr_ready.
- Backpressure: hold instr_ready=0 for 5 cycles with instr_valid=1.
  - instr and instr_pc unchanged; mem_req=0 throughout.
- Redirect during outstanding request: ack latency 4; redirect_pc=0x100 on cycle 2 of the request.
  - Stale word not presented; mem_addr held until ack, then next request at 0x100.
- Redirect same cycle as ack and same cycle as instr_ready, target 0x200.
  - No instr_valid for the old word; next fetch addr 0x200.
- Wrap: RESET_PC=32'hFFFF_FFFC.
  - Second fetch addr 0x0000_0000.
- FETCH_HALT_EN: return 32'hF800_0000 at 0x8.
  - After accept, halted=1, mem_req=0 for 10 cycles.
  - Redirect 0x40 gives halted=0, mem_addr=0x40.
